// File: rtl/fix_query_arbiter.sv
// Shares the fix_parser_top lookup port between NUM_REQ clients: arbitrate, issue, wait, respond.
// Define FIX_QARB_FIXED_PRIO_EN for fixed lowest-index priority; default build is round-robin.
module fix_query_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int LOOKUP_LAT = 8,
  parameter int TAG_W      = 32,
  parameter int MSG_W      = 10,
  parameter int VAL_W      = 256
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_i,
  input  logic [NUM_REQ*TAG_W-1:0] req_tag_i,
  input  logic [NUM_REQ*MSG_W-1:0] req_msg_i,
  output logic [NUM_REQ-1:0]       gnt_o,
  output logic [NUM_REQ-1:0]       rsp_valid_o,
  output logic                     rsp_err_o,
  output logic [VAL_W-1:0]         rsp_value_o,
  output logic [TAG_W-1:0]         find_tag_o,
  output logic [MSG_W-1:0]         message_num_o,
  output logic                     read_message_o,
  input  logic [VAL_W-1:0]         output_value_i,
  input  logic                     empty_i
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = 8;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t                          state, state_nxt;
  logic [IDX_W-1:0]                owner, win;
  logic                            win_vld;
  logic [CNT_W-1:0]                cnt;
  logic [NUM_REQ-1:0][TAG_W-1:0]   tag_arr;
  logic [NUM_REQ-1:0][MSG_W-1:0]   msg_arr;

  assign tag_arr = req_tag_i;
  assign msg_arr = req_msg_i;

`ifdef FIX_QARB_FIXED_PRIO_EN
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_i[IDX_W'(i)]) begin
        win     = IDX_W'(i);
        win_vld = 1'b1;
      end
    end
  end
`else
  logic [IDX_W-1:0] last;

  // Search starts one past the previous owner and wraps; first hit wins.
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      if (!win_vld && req_i[IDX_W'((int'(last) + i) % NUM_REQ)]) begin
        win     = IDX_W'((int'(last) + i) % NUM_REQ);
        win_vld = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      last <= IDX_W'(NUM_REQ - 1);
    else if (state == IDLE && win_vld)
      last <= win;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (win_vld) state_nxt = ISSUE;
      ISSUE:   state_nxt = empty_i ? RESP : WAIT;
      WAIT:    if (cnt == '0) state_nxt = RESP;
      default: state_nxt = IDLE;
    endcase
  end

  // Strobe must follow empty_i within ISSUE itself, so it is decoded from state, not flopped.
  assign read_message_o = (state == ISSUE) && !empty_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      owner         <= '0;
      cnt           <= '0;
      gnt_o         <= '0;
      rsp_valid_o   <= '0;
      rsp_err_o     <= 1'b0;
      rsp_value_o   <= '0;
      find_tag_o    <= '0;
      message_num_o <= '0;
    end else begin
      gnt_o       <= '0;
      rsp_valid_o <= '0;
      rsp_err_o   <= 1'b0;
      case (state)
        IDLE: if (win_vld) begin
          owner         <= win;
          find_tag_o    <= tag_arr[win];
          message_num_o <= msg_arr[win];
          gnt_o         <= NUM_REQ'(1) << win;
        end
        ISSUE: if (empty_i) begin
          rsp_value_o <= '0;
          rsp_err_o   <= 1'b1;
          rsp_valid_o <= NUM_REQ'(1) << owner;
        end else begin
          cnt <= CNT_W'(LOOKUP_LAT - 1);
        end
        WAIT: if (cnt == '0) begin
          rsp_value_o <= output_value_i;
          rsp_valid_o <= NUM_REQ'(1) << owner;
        end else begin
          cnt <= cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fix_query_arbiter.sv
// Scoreboard bench for fix_query_arbiter: stimulus pushes expected grants/responses, a monitor pops and compares.
module tb_fix_query_arbiter;
  localparam int NR = 4, LAT = 8, TW = 32, MW = 10, VW = 256;

  logic                clk = 1'b0;
  logic                rst;
  logic [NR-1:0]       req_i;
  logic [NR*TW-1:0]    req_tag_i;
  logic [NR*MW-1:0]    req_msg_i;
  logic [NR-1:0]       gnt_o, rsp_valid_o;
  logic                rsp_err_o;
  logic [VW-1:0]       rsp_value_o;
  logic [TW-1:0]       find_tag_o;
  logic [MW-1:0]       message_num_o;
  logic                read_message_o;
  logic [VW-1:0]       output_value_i;
  logic                empty_i;

  fix_query_arbiter #(.NUM_REQ(NR), .LOOKUP_LAT(LAT), .TAG_W(TW), .MSG_W(MW), .VAL_W(VW)) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .req_tag_i(req_tag_i), .req_msg_i(req_msg_i),
    .gnt_o(gnt_o), .rsp_valid_o(rsp_valid_o), .rsp_err_o(rsp_err_o), .rsp_value_o(rsp_value_o),
    .find_tag_o(find_tag_o), .message_num_o(message_num_o), .read_message_o(read_message_o),
    .output_value_i(output_value_i), .empty_i(empty_i)
  );

  always #5 clk = ~clk;

  function automatic logic [VW-1:0] good(input logic [TW-1:0] t, input logic [MW-1:0] m);
    return {t, 6'd0, m, {26{8'hA5}}};
  endfunction
  localparam logic [VW-1:0] JUNK = {8{32'hDEADBEEF}};

  // Parser model: value is junk until LAT cycles after the read strobe.
  int age = 0;
  always @(posedge clk) begin
    if (rst)                       age <= 0;
    else if (read_message_o)       age <= 1;
    else if (age > 0 && age < 1000) age <= age + 1;
  end
  assign output_value_i = (age >= LAT) ? good(find_tag_o, message_num_o) : JUNK;

  typedef struct {int cyc; logic [NR-1:0] mask; logic rd; logic [TW-1:0] tag; logic [MW-1:0] msg;} gexp_t;
  typedef struct {int cyc; logic [NR-1:0] mask; logic err; logic [VW-1:0] val; logic [TW-1:0] tag; logic [MW-1:0] msg;} rexp_t;
  gexp_t gq[$];
  rexp_t rq[$];
  gexp_t g;
  rexp_t r;

  int   errors = 0, checks = 0, cyc = 0;
  logic expect_zero = 1'b0, final_chk = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (expect_zero) begin
      chk("zero_gnt", gnt_o, 0);
      chk("zero_rsp_valid", rsp_valid_o, 0);
      chk("zero_rsp_err", rsp_err_o, 0);
      chk("zero_read", read_message_o, 0);
      chk("zero_value", rsp_value_o, 0);
      chk("zero_tag", find_tag_o, 0);
      chk("zero_msg", message_num_o, 0);
    end else if (!rst) begin
      if (gnt_o != '0) begin
        if (gq.size() == 0) begin
          checks++; errors++;
          $display("FAIL gnt_unexpected: got %b required none (cycle %0d)", gnt_o, cyc);
        end else begin
          g = gq.pop_front();
          chk("gnt_mask", gnt_o, g.mask);
          chk("gnt_cycle", cyc, g.cyc);
          chk("gnt_read", read_message_o, g.rd);
          chk("gnt_tag", find_tag_o, g.tag);
          chk("gnt_msg", message_num_o, g.msg);
        end
      end else if (read_message_o) begin
        checks++; errors++;
        $display("FAIL read_without_gnt: got 1 required 0 (cycle %0d)", cyc);
      end
      if (rsp_valid_o != '0) begin
        if (rq.size() == 0) begin
          checks++; errors++;
          $display("FAIL rsp_unexpected: got %b required none (cycle %0d)", rsp_valid_o, cyc);
        end else begin
          r = rq.pop_front();
          chk("rsp_mask", rsp_valid_o, r.mask);
          chk("rsp_cycle", cyc, r.cyc);
          chk("rsp_err", rsp_err_o, r.err);
          chk("rsp_value", rsp_value_o, r.val);
          chk("rsp_tag_stable", find_tag_o, r.tag);
          chk("rsp_msg_stable", message_num_o, r.msg);
        end
      end
    end
    if (final_chk) begin
      chk("gnt_queue_drained", gq.size(), 0);
      chk("rsp_queue_drained", rq.size(), 0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int k, input int gc, input logic emp, input logic [TW-1:0] t,
                      input logic [MW-1:0] m, input int rc);
    gq.push_back('{cyc: gc, mask: NR'(1) << k, rd: !emp, tag: t, msg: m});
    rq.push_back('{cyc: rc, mask: NR'(1) << k, err: emp, val: emp ? '0 : good(t, m), tag: t, msg: m});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    expect_zero = 1'b1;
    @(negedge clk);
    #1 expect_zero = 1'b0;
  endtask

  task automatic set_req(input int k, input logic [TW-1:0] t, input logic [MW-1:0] m);
    req_tag_i[k*TW +: TW] = t;
    req_msg_i[k*MW +: MW] = m;
  endtask

`ifdef FIX_QARB_FIXED_PRIO_EN
  int ord[6] = '{0, 0, 0, 0, 0, 1};
`else
  int ord[6] = '{0, 1, 2, 3, 0, 1};
`endif

  int t0;

  initial begin
    rst = 1'b1; req_i = '0; req_tag_i = '0; req_msg_i = '0; empty_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    expect_zero = 1'b1;
    @(negedge clk);
    #1 expect_zero = 1'b0;

    // Single query from requester 0
    step(); t0 = cyc;
    set_req(0, 32'h38, 10'd0); req_i = 4'b0001;
    push(0, t0 + 1, 1'b0, 32'h38, 10'd0, t0 + LAT + 2);
    step(); req_i = '0;
    repeat (LAT + 4) step();

    // Empty store: error response, no lookup strobe
    t0 = cyc;
    set_req(2, 32'h23, 10'd5); req_i = 4'b0100; empty_i = 1'b1;
    push(2, t0 + 1, 1'b1, 32'h23, 10'd5, t0 + 2);
    step(); req_i = '0;
    repeat (2) step(); empty_i = 1'b0;
    repeat (3) step();

    // Tag/msg stability while waiting
    t0 = cyc;
    set_req(1, 32'h37, 10'd3); req_i = 4'b0010;
    push(1, t0 + 1, 1'b0, 32'h37, 10'd3, t0 + LAT + 2);
    step(); req_i = '0;
    repeat (3) step();
    set_req(1, 32'hFFFF_FFFF, 10'h3FF);
    repeat (LAT + 3) step();

    // Arbitration with all requesters held high, then requester 0 drops
    do_reset();
    step(); t0 = cyc;
    for (int k = 0; k < NR; k++) set_req(k, 32'h100 + k, MW'(k + 1));
    req_i = 4'b1111;
    for (int n = 0; n < 6; n++)
      push(ord[n], t0 + 1 + (LAT + 3) * n, 1'b0, 32'h100 + ord[n], MW'(ord[n] + 1),
           t0 + LAT + 2 + (LAT + 3) * n);
    repeat (45) step(); req_i = 4'b1110;
    repeat (11) step(); req_i = '0;
    repeat (LAT + 4) step();

    // Reset during WAIT drops the query; arbitration restarts from requester 0
    t0 = cyc;
    set_req(0, 32'h38, 10'd0); req_i = 4'b0001;
    gq.push_back('{cyc: t0 + 1, mask: 4'b0001, rd: 1'b1, tag: 32'h38, msg: 10'd0});
    step(); req_i = '0;
    repeat (4) step();
    do_reset();
    repeat (LAT + 4) step();
    t0 = cyc;
    set_req(0, 32'h38, 10'd0); set_req(1, 32'h37, 10'd3); req_i = 4'b0011;
    push(0, t0 + 1, 1'b0, 32'h38, 10'd0, t0 + LAT + 2);
    push(1, t0 + LAT + 4, 1'b0, 32'h37, 10'd3, t0 + 2 * LAT + 5);
    step(); req_i = 4'b0010;
    repeat (LAT + 3) step(); req_i = '0;
    repeat (LAT + 4) step();

    final_chk = 1'b1;
    @(negedge clk);
    #1 final_chk = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
